// File: rtl/imem_loader_if.sv
// Stream-in and RAM-write signals of the instruction-memory loader.
// The loader uses the slave modport. The stream source and the RAM side use the master modport.
interface imem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader.
// Words from a valid/ready stream are written to consecutive
// instruction-RAM addresses, starting at 0.
// The CPU is held in reset until the halt word has been written.
// MAX_WORDS must not exceed 2**ADDR_W, so the write address never wraps.
module imem_loader #(
  parameter int              ADDR_W    = 9,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] END_MARK = 32'hffff_ffff,
  parameter int              MAX_WORDS = 512
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [ADDR_W:0] word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  // Word count at which the next non-marker beat fills the RAM.
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(MAX_WORDS - 1);

  state_t state;

  logic beat;
  assign beat = bus.in_valid && (state == LOAD);

  // The status outputs are decoded directly from the state register.
  assign bus.in_ready = (state == LOAD);
  assign busy         = (state == LOAD) || (state == FLUSH);
  assign done         = (state == DONE);
  assign overflow     = (state == ERROR);
  assign cpu_rst      = (state != DONE);

  // Load sequencing and the registered RAM write port.
  // The write strobe is cleared every cycle unless a beat is accepted.
  // As a result, FLUSH carries exactly the marker write, and ERROR carries
  // only the last word that fit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      word_count    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        IDLE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
          end
        end
        LOAD: begin
          if (beat) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= word_count[ADDR_W-1:0];
            bus.mem_wdata <= bus.in_data;
            word_count    <= word_count + 1'b1;
            if (bus.in_data == END_MARK) begin
              state <= FLUSH;
            end else if (word_count == LAST_SLOT) begin
              state <= ERROR;
            end
          end
        end
        FLUSH: begin
          state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader.
// A reference model tracks the next write address and the expected status
// outputs. Every accepted word pushes its expected RAM write into a queue.
// An independent monitor pops that queue whenever the RAM strobe is seen.
module tb_imem_loader;
  localparam int          ADDR_W    = 9;
  localparam int          DATA_W    = 32;
  localparam int          MAX_WORDS = 512;
  localparam logic [31:0] MARK      = 32'hffff_ffff;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            cpu_rst;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .END_MARK (MARK),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t expq[$];
  int  checks    = 0;
  int  failures  = 0;
  int  exp_count = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The monitor checks every RAM write against the next expected write, in order.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual addr=0x%0h data=0x%0h expected no write at %0t",
                 bus.mem_addr, bus.mem_wdata, $time);
      end else begin
        wr_t e;
        e = expq.pop_front();
        checkOutput("write_addr", 64'(bus.mem_addr), 64'(e.addr));
        checkOutput("write_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset is applied for three cycles. All outputs are checked while it is held.
  task automatic applyReset();
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",   64'(bus.in_ready), 64'd0);
    checkOutput("rst_mem_we",     64'(bus.mem_we),   64'd0);
    checkOutput("rst_mem_addr",   64'(bus.mem_addr), 64'd0);
    checkOutput("rst_mem_wdata",  64'(bus.mem_wdata), 64'd0);
    checkOutput("rst_word_count", 64'(word_count),   64'd0);
    checkOutput("rst_cpu_rst",    64'(cpu_rst),      64'd1);
    checkOutput("rst_busy",       64'(busy),         64'd0);
    checkOutput("rst_done",       64'(done),         64'd0);
    checkOutput("rst_overflow",   64'(overflow),     64'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Start is pulsed for one cycle. The model then begins a fresh image at address 0.
  task automatic applyStimulus_start();
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    exp_count = 0;
  endtask

  // Present one word after `gap` idle cycles.
  // The loader must be ready, so the word is accepted at the next rising edge.
  // Start is toggled at random while the word is held, and must have no effect.
  task automatic applyStimulus(input logic [31:0] d, input int gap);
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    start        = 1'($urandom_range(0, 1));
    checkOutput("in_ready", 64'(bus.in_ready), 64'd1);
    expq.push_back(wr_t'{ADDR_W'(exp_count), d});
    exp_count++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    start        = 1'b0;
  endtask

  // Load a complete image that ends in the marker.
  // After the marker there must be one flush cycle, and then the CPU is released.
  task automatic loadImage(input logic [31:0] img[$], input int gap_mode);
    applyStimulus_start();
    foreach (img[i]) begin
      applyStimulus(img[i], (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode);
    end
    checkOutput("flush_busy",     64'(busy),         64'd1);
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("flush_cpu_rst",  64'(cpu_rst),      64'd1);
    checkOutput("flush_done",     64'(done),         64'd0);
    @(negedge clk);
    checkOutput("done_flag",       64'(done),       64'd1);
    checkOutput("done_cpu_rst",    64'(cpu_rst),    64'd0);
    checkOutput("done_busy",       64'(busy),       64'd0);
    checkOutput("done_overflow",   64'(overflow),   64'd0);
    checkOutput("done_word_count", 64'(word_count), 64'(exp_count));
  endtask

  logic [31:0] image[$];
  logic [31:0] w;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);

    // Reference program, loaded back-to-back.
    applyReset();
    image = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, MARK};
    loadImage(image, 0);

    // While in DONE, start and stream activity are ignored.
    for (int i = 0; i < 10; i++) begin
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(negedge clk);
      checkOutput("done_hold_cpu_rst",  64'(cpu_rst),      64'd0);
      checkOutput("done_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    // The same program, with one idle cycle between words.
    applyReset();
    loadImage(image, 1);

    // Overflow case: 512 zero words and no marker.
    applyReset();
    applyStimulus_start();
    for (int i = 0; i < MAX_WORDS; i++) applyStimulus(32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ovf_overflow",   64'(overflow),     64'd1);
      checkOutput("ovf_cpu_rst",    64'(cpu_rst),      64'd1);
      checkOutput("ovf_in_ready",   64'(bus.in_ready), 64'd0);
      checkOutput("ovf_word_count", 64'(word_count),   64'(MAX_WORDS));
      @(negedge clk);
    end
    image = '{32'h1234_5678, MARK};
    loadImage(image, 0);

    // Reset in the middle of a load, then restart from address 0.
    applyReset();
    applyStimulus_start();
    applyStimulus(32'hAAAA_0001, 0);
    applyStimulus(32'hAAAA_0002, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_word_count", 64'(word_count),   64'd0);
    checkOutput("midrst_mem_we",     64'(bus.mem_we),   64'd0);
    checkOutput("midrst_in_ready",   64'(bus.in_ready), 64'd0);
    checkOutput("midrst_busy",       64'(busy),         64'd0);
    image = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, MARK};
    loadImage(image, 0);

    // Randomized images with random gaps between words.
    for (int t = 0; t < 6; t++) begin
      applyReset();
      image = {};
      for (int i = 0; i < int'($urandom_range(0, 30)); i++) begin
        w = $urandom;
        if (w == MARK) w = 32'h0;
        image.push_back(w);
      end
      image.push_back(MARK);
      loadImage(image, -1);
    end

    repeat (2) @(negedge clk);
    checkOutput("pending_writes", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
